// File: rtl/router_out_arbiter.sv
// router_out_arbiter: packet-level round-robin arbiter sharing one router output among NPORTS sources.
// Optional macro ARB_TIMEOUT_EN adds an idle-beat watchdog that force-releases a stalled grant.
module router_out_arbiter #(
    parameter int NPORTS  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORTS-1:0]         req,
    input  logic [NPORTS-1:0]         valid,
    input  logic [NPORTS-1:0]         eop,
    input  logic                      out_ready,
    input  logic [NPORTS-1:0]         en_mask,
    input  logic                      cnt_clr,
    output logic [NPORTS-1:0]         gnt,
    output logic [$clog2(NPORTS)-1:0] gnt_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          pkt_count,
    output logic                      timeout_err
);

    localparam int IDW = $clog2(NPORTS);
    localparam logic [NPORTS-1:0] ONE_HOT0 = {{(NPORTS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_r;
    logic [IDW-1:0]    ptr_r;
    logic [NPORTS-1:0] gnt_r;
    logic [IDW-1:0]    gnt_id_r;
    logic              busy_r;
    logic [CNT_W-1:0]  pkt_count_r;

    logic [NPORTS-1:0] eligible_s;
    logic              found_s;
    logic [IDW-1:0]    winner_s;
    logic [IDW-1:0]    cand_s;
    int                idx_v;
    logic [IDW-1:0]    ptr_next_s;
    logic              eop_rel_s;
    logic              expire_s;
    logic              release_s;

    assign eligible_s = req & en_mask;

    // Rotating-priority search: first eligible source at or after the round-robin pointer.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IDW{1'b0}};
        cand_s   = {IDW{1'b0}};
        idx_v    = 0;
        for (int k = 0; k < NPORTS; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= NPORTS) begin
                idx_v = idx_v - NPORTS;
            end else begin
                idx_v = idx_v;
            end
            cand_s = IDW'(idx_v);
            if (!found_s && eligible_s[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pointer value that follows the current owner, wrapping at NPORTS.
    always_comb begin
        if (gnt_id_r == IDW'(NPORTS - 1)) begin
            ptr_next_s = {IDW{1'b0}};
        end else begin
            ptr_next_s = gnt_id_r + IDW'(1);
        end
    end

    // Only the owner's beats matter; other sources' valid/eop are ignored while locked.
    assign eop_rel_s = (state_r == ST_LOCKED) && valid[gnt_id_r] && eop[gnt_id_r];
    assign release_s = eop_rel_s || expire_s;

    // Grant state machine with registered grant, owner index and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {IDW{1'b0}};
            gnt_r    <= {NPORTS{1'b0}};
            gnt_id_r <= {IDW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s && out_ready) begin
                        state_r  <= ST_LOCKED;
                        gnt_r    <= ONE_HOT0 << winner_s;
                        gnt_id_r <= winner_s;
                        busy_r   <= 1'b1;
                    end else begin
                        gnt_r    <= {NPORTS{1'b0}};
                        busy_r   <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (release_s) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {NPORTS{1'b0}};
                        busy_r  <= 1'b0;
                        ptr_r   <= ptr_next_s;
                    end else begin
                        gnt_r   <= gnt_r;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt_r    <= {NPORTS{1'b0}};
                    gnt_id_r <= {IDW{1'b0}};
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Completed-packet counter; clear wins over a same-cycle increment, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            pkt_count_r <= {CNT_W{1'b0}};
        end else if (eop_rel_s) begin
            pkt_count_r <= pkt_count_r + CNT_W'(1);
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt_r;
    logic          timeout_err_r;

    // Expiry fires on the beat-less cycle that would bring the idle count up to TIMEOUT.
    assign expire_s = (state_r == ST_LOCKED) && !valid[gnt_id_r]
                      && (idle_cnt_r == TW'(TIMEOUT - 1));

    // Idle-beat watchdog; the error pulse lines up with busy falling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_r    <= {TW{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_r != ST_LOCKED) || valid[gnt_id_r] || expire_s) begin
                idle_cnt_r <= {TW{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + TW'(1);
            end
            timeout_err_r <= expire_s;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign expire_s    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign busy      = busy_r;
    assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench for router_out_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the packet round-robin rules.
module tb_router_out_arbiter;

    localparam int NP = 4;
    localparam int TO = 64;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0, valid = 4'b0, eop = 4'b0, en_mask = 4'b0;
    logic       out_ready = 1'b0, cnt_clr = 1'b0;

    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [15:0] pkt_count;
    logic        timeout_err;

    logic [3:0]  gnt_n;
    logic [1:0]  gnt_id_n;
    logic        busy_n;
    logic [3:0]  pkt_count_n;
    logic        timeout_err_n;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_locked;
    int m_owner, m_ptr, m_count, m_idle;
    bit m_err;

    router_out_arbiter #(.NPORTS(NP), .CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .valid(valid), .eop(eop),
        .out_ready(out_ready), .en_mask(en_mask), .cnt_clr(cnt_clr),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .pkt_count(pkt_count),
        .timeout_err(timeout_err)
    );

    router_out_arbiter #(.NPORTS(NP), .CNT_W(4), .TIMEOUT(TO)) dut_n (
        .clk(clk), .reset(reset), .req(req), .valid(valid), .eop(eop),
        .out_ready(out_ready), .en_mask(en_mask), .cnt_clr(cnt_clr),
        .gnt(gnt_n), .gnt_id(gnt_id_n), .busy(busy_n), .pkt_count(pkt_count_n),
        .timeout_err(timeout_err_n)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_count = 0; m_idle = 0; m_err = 1'b0;
    endfunction

    // One clock of the arbitration rules applied to the currently driven inputs.
    function automatic void model_update();
        bit inc = 1'b0;
        bit done = 1'b0;
        m_err = 1'b0;
        if (m_locked) begin
            if (valid[m_owner] && eop[m_owner]) begin
                m_locked = 1'b0; m_ptr = (m_owner + 1) % NP; inc = 1'b1;
            end else if (TO_EN) begin
                if (valid[m_owner]) m_idle = 0;
                else m_idle = m_idle + 1;
                if (m_idle == TO) begin
                    m_locked = 1'b0; m_ptr = (m_owner + 1) % NP; m_err = 1'b1;
                end
            end
        end else if (((req & en_mask) != 4'b0) && out_ready) begin
            for (int k = 0; k < NP; k++) begin
                int idx = (m_ptr + k) % NP;
                if (!done && req[idx] && en_mask[idx]) begin
                    done = 1'b1; m_locked = 1'b1; m_owner = idx; m_idle = 0;
                end
            end
        end
        if (cnt_clr) m_count = 0;
        else if (inc) m_count = (m_count + 1) % 65536;
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = 4'b0; valid = 4'b0; eop = 4'b0; cnt_clr = 1'b0;
        en_mask = 4'hF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt_id: got %0d want 0", gnt_id); end
        total++; if (pkt_count !== 16'h0000) begin bad++; $display("FAIL rst_cnt: got %h want 0000", pkt_count); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", timeout_err); end
        apply_reset();
    endtask

    task automatic test_single_source();
        req = 4'b0001; en_mask = 4'hF; out_ready = 1'b1;
        step();
        total++; if (gnt !== 4'b0001 || busy !== 1'b1 || gnt_id !== 2'd0) begin
            bad++; $display("FAIL single_grant: got gnt=%b busy=%b id=%0d want 0001/1/0", gnt, busy, gnt_id);
        end
        valid = 4'b0001; eop = 4'b0000;
        step();
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_hold: got busy=%b want 1", busy); end
        eop = 4'b0001;
        step();
        total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", pkt_count); end
        valid = 4'b0; eop = 4'b0; req = 4'b1111;
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL single_ptr: got %b want 0010", gnt); end
        valid = 4'b0010; eop = 4'b0010;
        step();
        valid = 4'b0; eop = 4'b0; req = 4'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            step();
            total++; if (gnt !== exp_g || gnt_id !== 2'(i % 4)) begin
                bad++; $display("FAIL rr_order%0d: got gnt=%b id=%0d want %b", i, gnt, gnt_id, exp_g);
            end
            valid = exp_g; eop = 4'b0;
            step();
            eop = exp_g;
            step();
            total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
                bad++; $display("FAIL rr_gap%0d: got gnt=%b busy=%b want 0000/0", i, gnt, busy);
            end
            valid = 4'b0; eop = 4'b0;
        end
        total++; if (pkt_count !== 16'd5) begin bad++; $display("FAIL rr_cnt: got %0d want 5", pkt_count); end
        req = 4'b0;
        step();
    endtask

    task automatic test_mask();
        apply_reset();
        req = 4'b0101; en_mask = 4'b0100;
        step();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mask_grant: got %b want 0100", gnt); end
        req = 4'b0100; en_mask = 4'b0000; out_ready = 1'b0; valid = 4'b0001; eop = 4'b0001;
        step();
        total++; if (gnt !== 4'b0100 || busy !== 1'b1 || pkt_count !== 16'd0) begin
            bad++; $display("FAIL mask_lock: got gnt=%b busy=%b cnt=%0d want 0100/1/0", gnt, busy, pkt_count);
        end
        valid = 4'b0100; eop = 4'b0100;
        step();
        total++; if (busy !== 1'b0 || pkt_count !== 16'd1) begin
            bad++; $display("FAIL mask_release: got busy=%b cnt=%0d want 0/1", busy, pkt_count);
        end
        en_mask = 4'hF; out_ready = 1'b1; valid = 4'b0; eop = 4'b0; req = 4'b0;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 4'b0001;
        step();
        valid = 4'b0001; eop = 4'b0001;
        step();
        valid = 4'b0; eop = 4'b0; req = 4'b0010;
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_grant: got %b want 0010", gnt); end
        valid = 4'b0010;
        step();
        #3 reset = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000 || busy !== 1'b0 || pkt_count !== 16'd0) begin
            bad++; $display("FAIL mid_async: got gnt=%b busy=%b cnt=%0d want 0000/0/0", gnt, busy, pkt_count);
        end
        model_reset();
        valid = 4'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = 4'b0011;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_ptr0: got %b want 0001", gnt); end
        valid = 4'b0001; eop = 4'b0001;
        step();
        valid = 4'b0; eop = 4'b0; req = 4'b0;
        step();
    endtask

    task automatic test_wrap_clear();
        apply_reset();
        req = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            step();
            valid = 4'b0001; eop = 4'b0001;
            step();
            valid = 4'b0; eop = 4'b0;
            if (i == 14) begin
                total++; if (pkt_count_n !== 4'hF) begin bad++; $display("FAIL wrap_max: got %h want f", pkt_count_n); end
            end
        end
        total++; if (pkt_count_n !== 4'h0 || pkt_count !== 16'd16) begin
            bad++; $display("FAIL wrap_zero: got n=%h w=%0d want 0/16", pkt_count_n, pkt_count);
        end
        step();
        valid = 4'b0001; eop = 4'b0001; cnt_clr = 1'b1;
        step();
        total++; if (pkt_count !== 16'd0 || pkt_count_n !== 4'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL clr_prio: got cnt=%0d n=%h busy=%b want 0/0/0", pkt_count, pkt_count_n, busy);
        end
        cnt_clr = 1'b0; valid = 4'b0; eop = 4'b0; req = 4'b0;
        step();
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 4'b1000;
        step();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL to_grant: got %b want 1000", gnt); end
        req = 4'b0;
        repeat (63) step();
        total++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL to_hold63: got busy=%b err=%b want 1/0", busy, timeout_err);
        end
`ifdef ARB_TIMEOUT_EN
        step();
        total++; if (busy !== 1'b0 || gnt !== 4'b0000 || timeout_err !== 1'b1 || pkt_count !== 16'd0) begin
            bad++; $display("FAIL to_expire: got busy=%b gnt=%b err=%b cnt=%0d want 0/0000/1/0",
                            busy, gnt, timeout_err, pkt_count);
        end
        step();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_pulse: got err=%b want 0", timeout_err); end
        req = 4'b1010;
        step();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL to_ptr: got %b want 0010", gnt); end
        valid = 4'b0010; eop = 4'b0010;
        step();
`else
        repeat (10) step();
        total++; if (busy !== 1'b1 || gnt !== 4'b1000 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL to_locked: got busy=%b gnt=%b err=%b want 1/1000/0", busy, gnt, timeout_err);
        end
        valid = 4'b1000; eop = 4'b1000;
        step();
        total++; if (busy !== 1'b0 || pkt_count !== 16'd1) begin
            bad++; $display("FAIL to_eop: got busy=%b cnt=%0d want 0/1", busy, pkt_count);
        end
`endif
        valid = 4'b0; eop = 4'b0; req = 4'b0;
        step();
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            req       = 4'($urandom_range(0, 15));
            valid     = 4'($urandom_range(0, 15));
            eop       = 4'($urandom_range(0, 15));
            en_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            step();
            exp_g = m_locked ? (4'b0001 << m_owner) : 4'b0000;
            total++; if (gnt !== exp_g || busy !== m_locked) begin
                bad++; $display("FAIL rnd_gnt@%0d: got gnt=%b busy=%b want %b/%b", i, gnt, busy, exp_g, m_locked);
            end
            if (m_locked) begin
                total++; if (gnt_id !== 2'(m_owner)) begin
                    bad++; $display("FAIL rnd_id@%0d: got %0d want %0d", i, gnt_id, m_owner);
                end
            end
            total++; if (pkt_count !== 16'(m_count) || pkt_count_n !== 4'(m_count % 16)) begin
                bad++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d", i, pkt_count, pkt_count_n, m_count);
            end
            total++; if (timeout_err !== m_err) begin
                bad++; $display("FAIL rnd_err@%0d: got %b want %b", i, timeout_err, m_err);
            end
        end
        cnt_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_source();
        test_round_robin();
        test_mask();
        test_reset_mid();
        test_wrap_clear();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
